// File: rtl/ifetch_imc.sv
// Instruction memory controller: credit-limited fetch request forwarding,
// in-order response FIFO toward ifetch, and flush-driven discard of stale responses.
module ifetch_imc #(
    parameter int XLEN            = 32,
    parameter int IFETCHW         = 128,
    parameter int MAX_OUTSTANDING = 4,
    parameter int RESP_DEPTH      = 4
) (
    input  logic               clk,
    input  logic               arst,
    input  logic               im_addr_val,
    output logic               im_addr_rdy,
    input  logic [XLEN-1:0]    im_addr,
    input  logic               im_flush_val,
    output logic               im_rdata_val,
    input  logic               im_rdata_rdy,
    output logic [IFETCHW-1:0] im_rdata,
    output logic               im_rdata_err,
    output logic               mem_req_val,
    input  logic               mem_req_rdy,
    output logic [XLEN-1:0]    mem_req_addr,
    input  logic               mem_rsp_val,
    input  logic [IFETCHW-1:0] mem_rsp_data,
    input  logic               mem_rsp_err,
    output logic               imc_busy
);
    localparam int IW = $clog2(MAX_OUTSTANDING + 1);
    localparam int FW = $clog2(RESP_DEPTH + 1);
    localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int SW = ((IW > FW) ? IW : FW) + 1;
    localparam int EW = IFETCHW + 1;

    logic [IW-1:0] inflight_reg, inflight_next;
    logic [IW-1:0] discard_reg, discard_next;
    logic [FW-1:0] fcnt_reg, fcnt_next;
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [EW-1:0] fifo_mem [RESP_DEPTH];

    logic [IW-1:0] live;
    logic [SW-1:0] occupancy;
    logic          credit_ok, req_acc, drop, push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Every live request must already own a FIFO slot, because responses cannot be stalled.
    assign live      = inflight_reg - discard_reg;
    assign occupancy = SW'(live) + SW'(fcnt_reg);
    assign credit_ok = !arst && (inflight_reg < IW'(MAX_OUTSTANDING))
                             && (occupancy < SW'(RESP_DEPTH));

    assign mem_req_val  = im_addr_val & credit_ok;
    assign mem_req_addr = im_addr;
    assign im_addr_rdy  = mem_req_rdy & credit_ok;
    assign req_acc      = im_addr_val & im_addr_rdy;

    assign drop = mem_rsp_val & ((discard_reg != '0) | im_flush_val);
    assign push = mem_rsp_val & ~drop;

    assign im_rdata_val = (fcnt_reg != '0);
    assign pop          = im_rdata_val & im_rdata_rdy;
    assign {im_rdata_err, im_rdata} = fifo_mem[rd_ptr_reg];
    assign imc_busy     = (inflight_reg != '0) | (fcnt_reg != '0);

    always_comb begin
        inflight_next = inflight_reg + IW'(req_acc) - IW'(mem_rsp_val);
        discard_next  = discard_reg;
        fcnt_next     = fcnt_reg;
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        if (im_flush_val) begin
            // A request accepted in the flush cycle is post-flush and is not counted here.
            discard_next = inflight_reg - IW'(mem_rsp_val);
            fcnt_next    = '0;
            wr_ptr_next  = '0;
            rd_ptr_next  = '0;
        end else begin
            if (drop)
                discard_next = discard_reg - IW'(1);
            if (push)
                wr_ptr_next = ptr_inc(wr_ptr_reg);
            if (pop)
                rd_ptr_next = ptr_inc(rd_ptr_reg);
            fcnt_next = fcnt_reg + FW'(push) - FW'(pop);
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            inflight_reg <= '0;
            discard_reg  <= '0;
            fcnt_reg     <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
        end else begin
            inflight_reg <= inflight_next;
            discard_reg  <= discard_next;
            fcnt_reg     <= fcnt_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
        end
    end

    // Storage needs no reset: contents are only visible while fcnt is non-zero.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= {mem_rsp_err, mem_rsp_data};
    end

    always_ff @(posedge clk) begin
        if (!arst && push)
            assert (fcnt_reg < FW'(RESP_DEPTH));
    end
endmodule

// File: tb/tb_ifetch_imc.sv
// Bench for ifetch_imc: queue-based memory/ifetch reference model, a table of
// credit-limit vectors, directed flush/error/reset sequences, then random traffic.
module tb_ifetch_imc;
    localparam int XLEN  = 32;
    localparam int FW    = 128;
    localparam int MAXO  = 4;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            arst;
    logic            im_addr_val, im_addr_rdy, im_flush_val;
    logic [XLEN-1:0] im_addr;
    logic            im_rdata_val, im_rdata_rdy, im_rdata_err;
    logic [FW-1:0]   im_rdata;
    logic            mem_req_val, mem_req_rdy;
    logic [XLEN-1:0] mem_req_addr;
    logic            mem_rsp_val, mem_rsp_err;
    logic [FW-1:0]   mem_rsp_data;
    logic            imc_busy;

    ifetch_imc #(.XLEN(XLEN), .IFETCHW(FW), .MAX_OUTSTANDING(MAXO), .RESP_DEPTH(DEPTH)) dut (
        .clk(clk), .arst(arst),
        .im_addr_val(im_addr_val), .im_addr_rdy(im_addr_rdy), .im_addr(im_addr),
        .im_flush_val(im_flush_val),
        .im_rdata_val(im_rdata_val), .im_rdata_rdy(im_rdata_rdy),
        .im_rdata(im_rdata), .im_rdata_err(im_rdata_err),
        .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_addr(mem_req_addr),
        .mem_rsp_val(mem_rsp_val), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
        .imc_busy(imc_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] addr;
        logic [FW-1:0]   data;
        logic            err;
        logic            cancel;
        int              due;
    } req_t;

    typedef struct {
        logic av;
        logic fl;
        logic rr;
        logic exp_acc;
    } vec_t;

    req_t            pend[$];   // issued to memory, not yet answered
    req_t            dq[$];     // answered and waiting for ifetch
    logic [XLEN-1:0] got[$];
    logic            got_err[$];
    vec_t            vt[$];

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   serial = 0;
    int   lat   = 2;
    int   err_idx = -1;
    logic rnd_err = 1'b0;
    logic acc;

    task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [FW-1:0] mkdata(input logic [XLEN-1:0] a, input int s);
        return {a ^ 32'hDEADBEEF, a, 32'(s), ~a};
    endfunction

    task automatic step(input logic av, input logic [XLEN-1:0] a, input logic fl,
                        input logic rr, input logic mr, output logic acc_o);
        logic rsp, exp_rdy, exp_val;
        int   live;
        @(negedge clk);
        im_addr_val  = av;
        im_addr      = a;
        im_flush_val = fl;
        im_rdata_rdy = rr;
        mem_req_rdy  = mr;
        rsp = (pend.size() > 0) && (pend[0].due <= cyc);
        mem_rsp_val  = rsp;
        mem_rsp_err  = 1'b0;
        mem_rsp_data = {$urandom, $urandom, $urandom, $urandom};
        if (rsp) begin
            mem_rsp_data = pend[0].data;
            mem_rsp_err  = pend[0].err;
        end
        #1;
        live = 0;
        foreach (pend[i]) if (!pend[i].cancel) live++;
        exp_rdy = (pend.size() < MAXO) && (live + dq.size() < DEPTH);
        exp_val = (dq.size() != 0);
        chk("mem_req_val", FW'(mem_req_val), FW'(av & exp_rdy));
        chk("im_addr_rdy", FW'(im_addr_rdy), FW'(mr & exp_rdy));
        if (av && exp_rdy) chk("mem_req_addr", FW'(mem_req_addr), FW'(a));
        chk("im_rdata_val", FW'(im_rdata_val), FW'(exp_val));
        if (exp_val) begin
            chk("im_rdata", im_rdata, dq[0].data);
            chk("im_rdata_err", FW'(im_rdata_err), FW'(dq[0].err));
        end
        chk("imc_busy", FW'(imc_busy), FW'((pend.size() != 0) || exp_val));
        acc_o = av & mr & exp_rdy;
        @(posedge clk);
        if (exp_val && rr) begin
            got.push_back(dq[0].addr);
            got_err.push_back(dq[0].err);
            void'(dq.pop_front());
        end
        if (rsp) begin
            req_t r;
            r = pend.pop_front();
            if (!r.cancel && !fl) dq.push_back(r);
        end
        if (fl) begin
            dq.delete();
            foreach (pend[i]) pend[i].cancel = 1'b1;
        end
        if (acc_o) begin
            req_t n;
            n.addr   = a;
            n.data   = mkdata(a, serial);
            n.err    = (serial == err_idx) || (rnd_err && ($urandom_range(0, 7) == 0));
            n.cancel = 1'b0;
            n.due    = cyc + lat;
            pend.push_back(n);
            serial++;
        end
        cyc++;
    endtask

    task automatic idle(input int n, input logic rr);
        logic a_unused;
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, rr, 1'b1, a_unused);
    endtask

    function automatic vec_t mkvec(input logic av, input logic fl, input logic rr, input logic ea);
        vec_t v;
        v.av = av; v.fl = fl; v.rr = rr; v.exp_acc = ea;
        return v;
    endfunction

    initial begin
        // Credit-limit vectors, memory latency 2: four accepts fill the FIFO,
        // two pops free exactly two more credits.
        for (int i = 0; i < 4; i++) vt.push_back(mkvec(1, 0, 0, 1));
        for (int i = 0; i < 6; i++) vt.push_back(mkvec(1, 0, 0, 0));
        vt.push_back(mkvec(1, 0, 1, 0));
        vt.push_back(mkvec(1, 0, 1, 1));
        vt.push_back(mkvec(1, 0, 0, 1));
        for (int i = 0; i < 3; i++) vt.push_back(mkvec(1, 0, 0, 0));
        for (int i = 0; i < 6; i++) vt.push_back(mkvec(0, 0, 1, 0));

        arst = 1'b1;
        im_addr_val = 0; im_addr = '0; im_flush_val = 0; im_rdata_rdy = 0;
        mem_req_rdy = 1; mem_rsp_val = 0; mem_rsp_data = '0; mem_rsp_err = 0;
        #3;
        chk("reset im_rdata_val", FW'(im_rdata_val), '0);
        chk("reset mem_req_val", FW'(mem_req_val), '0);
        chk("reset im_addr_rdy", FW'(im_addr_rdy), '0);
        chk("reset imc_busy", FW'(imc_busy), '0);
        @(negedge clk);
        arst = 1'b0;

        // Streaming
        lat = 2; got.delete();
        step(1, 32'h100, 0, 1, 1, acc);
        step(1, 32'h110, 0, 1, 1, acc);
        step(1, 32'h120, 0, 1, 1, acc);
        idle(6, 1);
        chk("stream count", FW'(got.size()), FW'(3));
        for (int i = 0; i < 3 && i < got.size(); i++)
            chk("stream order", FW'(got[i]), FW'(32'h100 + 16 * i));

        // Credit table
        for (int i = 0; i < vt.size(); i++) begin
            step(vt[i].av, 32'h400 + 16 * i, vt[i].fl, vt[i].rr, 1'b1, acc);
            chk($sformatf("credit vec %0d accept", i), FW'(acc & im_addr_rdy), FW'(vt[i].exp_acc));
        end

        // Flush with three in flight plus a simultaneous post-flush request
        lat = 4; got.delete();
        step(1, 32'h1A0, 0, 1, 1, acc);
        step(1, 32'h1B0, 0, 1, 1, acc);
        step(1, 32'h1C0, 0, 1, 1, acc);
        step(1, 32'h200, 1, 1, 1, acc);
        chk("flush-cycle accept", FW'(acc), FW'(1));
        idle(10, 1);
        chk("flush delivered count", FW'(got.size()), FW'(1));
        if (got.size() > 0) chk("flush delivered addr", FW'(got[0]), FW'(32'h200));

        // Flush coinciding with a response, two in flight
        lat = 2; got.delete();
        step(1, 32'h300, 0, 1, 1, acc);
        step(1, 32'h310, 0, 1, 1, acc);
        step(0, '0, 1, 1, 1, acc);
        idle(6, 1);
        chk("flush+rsp delivered count", FW'(got.size()), FW'(0));

        // Bus error on the second beat only
        lat = 2; got.delete(); got_err.delete();
        err_idx = serial + 1;
        step(1, 32'h340, 0, 1, 1, acc);
        step(1, 32'h350, 0, 1, 1, acc);
        step(1, 32'h360, 0, 1, 1, acc);
        idle(6, 1);
        err_idx = -1;
        chk("err beat count", FW'(got_err.size()), FW'(3));
        for (int i = 0; i < 3 && i < got_err.size(); i++)
            chk("err flag per beat", FW'(got_err[i]), FW'(i == 1));

        // Steady push+pop around a nearly full FIFO, crossing pointer wrap
        lat = 1;
        for (int i = 0; i < 3; i++) step(1, 32'h700 + 16 * i, 0, 0, 1, acc);
        idle(1, 0);
        for (int i = 0; i < 20; i++) step(1, 32'h800 + 16 * i, 0, 1'($urandom_range(0, 1)), 1, acc);
        idle(8, 1);

        // Asynchronous reset mid-stream: two in flight, two buffered
        lat = 2;
        for (int i = 0; i < 4; i++) step(1, 32'h500 + 16 * i, 0, 0, 1, acc);
        @(negedge clk);
        im_addr_val = 1; mem_req_rdy = 1; im_flush_val = 0; mem_rsp_val = 0;
        #2 arst = 1'b1;
        #1;
        chk("midreset im_rdata_val", FW'(im_rdata_val), '0);
        chk("midreset mem_req_val", FW'(mem_req_val), '0);
        chk("midreset im_addr_rdy", FW'(im_addr_rdy), '0);
        chk("midreset imc_busy", FW'(imc_busy), '0);
        pend.delete(); dq.delete(); got.delete();
        im_addr_val = 0;
        @(negedge clk);
        arst = 1'b0;
        step(1, 32'h600, 0, 1, 1, acc);
        idle(5, 1);
        chk("post-reset count", FW'(got.size()), FW'(1));
        if (got.size() > 0) chk("post-reset addr", FW'(got[0]), FW'(32'h600));

        // Random traffic against the model
        rnd_err = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            lat = $urandom_range(1, 4);
            step(1'($urandom_range(0, 9) < 7), $urandom, 1'($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) < 7), acc);
        end
        idle(12, 1);
        chk("final idle busy", FW'(imc_busy), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
